// File: rtl/cla_pkg.sv
// Shared definitions for the 32-bit two-level carry-lookahead adder.
// cla4_carries is the 4-way lookahead used at both the bit and group level.
package cla_pkg;

    localparam int WIDTH   = 32;
    localparam int GROUP   = 4;
    localparam int NGROUPS = WIDTH / GROUP;

    typedef logic [31:0] word_t;

    // Flattened lookahead: returns {c4,c3,c2,c1} from generate/propagate and carry-in.
    function automatic logic [3:0] cla4_carries(input logic [3:0] g,
                                                input logic [3:0] p,
                                                input logic       c);
        logic [3:0] co;
        co[0] = g[0] | (p[0] & c);
        co[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        co[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        co[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c);
        return co;
    endfunction

endpackage

// File: rtl/cla4_block.sv
// 4-bit lookahead group: sum bits from the group carry-in, plus group
// propagate/generate exported to the top-level lookahead unit.
module cla4_block
    import cla_pkg::*;
(
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             pg,
    output logic             gg
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] c;

    always_comb begin
        p  = a ^ b;
        g  = a & b;
        c  = cla4_carries(g, p, ci);
        s  = p ^ {c[2:0], ci};
        pg = &p;
        // Group generate is independent of ci so the top unit never waits on it.
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule

// File: rtl/cla_adder32.sv
// Registered 32-bit carry-lookahead adder: eight 4-bit groups, two lookahead
// supergroups of four groups each, result and carry-out captured every cycle.
module cla_adder32
    import cla_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [NGROUPS-1:0] gp;
    logic [NGROUPS-1:0] gg;
    logic [NGROUPS:0]   c_grp;
    logic [3:0]         c_lo;
    logic [3:0]         c_hi;
    word_t              sum_c;
    word_t              sum_p1;
    logic               cout_p1;

    genvar k;
    generate
        for (k = 0; k < NGROUPS; k++) begin : g_grp
            cla4_block u_cla4 (
                .a  (a[k*GROUP +: GROUP]),
                .b  (b[k*GROUP +: GROUP]),
                .ci (c_grp[k]),
                .s  (sum_c[k*GROUP +: GROUP]),
                .pg (gp[k]),
                .gg (gg[k])
            );
        end
    endgenerate

    // Upper supergroup takes its carry-in from the lower one: at most two in series.
    always_comb begin
        c_lo  = cla4_carries(gg[3:0], gp[3:0], cin);
        c_hi  = cla4_carries(gg[7:4], gp[7:4], c_lo[3]);
        c_grp = {c_hi, c_lo, cin};
    end

    // ---- stage p1: registered result ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
        end else begin
            sum_p1  <= sum_c;
            cout_p1 <= c_grp[NGROUPS];
        end
    end

    assign sum  = sum_p1;
    assign cout = cout_p1;

endmodule

// File: tb/tb_cla_adder32.sv
// Scoreboard bench for cla_adder32: driver queues expected results, a monitor
// compares them one edge later; reset behaviour is checked directly.
module tb_cla_adder32;

    typedef struct {
        logic [31:0] s;
        logic        c;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;

    int   tests;
    int   fails;
    exp_t sb[$];

    cla_adder32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] as, input logic ac,
                         input logic [31:0] es, input logic ec);
        tests++;
        if (as !== es || ac !== ec) begin
            fails++;
            $display("FAIL %s: got sum=%08h cout=%b, expected sum=%08h cout=%b",
                     name, as, ac, es, ec);
        end
    endtask

    task automatic drive(input string name, input logic [31:0] va, input logic [31:0] vb,
                         input logic vc, input logic [31:0] es, input logic ec);
        exp_t e;
        @(negedge clk);
        a   = va;
        b   = vb;
        cin = vc;
        e.s = es;
        e.c = ec;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: every edge taken out of reset retires one queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst_n && sb.size() > 0) begin
                #1;
                e = sb.pop_front();
                check(e.name, sum, cout, e.s, e.c);
            end
        end
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [32:0] ref33;
        int          guard;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        a     = 32'hFFFF_FFFF;
        b     = 32'h0000_0001;
        cin   = 1'b1;

        repeat (3) @(posedge clk);
        #1 check("reset_hold", sum, cout, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        drive("basic_1f",      32'h001F_001F, 32'h000C_001F, 1'b0, 32'h002B_003E, 1'b0);
        drive("basic_1234",    32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0);
        drive("full_prop",     32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
        drive("grp_boundary",  32'h0000_000F, 32'h0000_0000, 1'b1, 32'h0000_0010, 1'b0);
        drive("msb_overflow",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
        drive("max_cin",       32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
        drive("cin_only",      32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0);
        drive("half_carry",    32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0);
        drive("alt_prop",      32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1);
        drive("all_prop_nc",   32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0);
        drive("signed_wrap",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0);
        drive("max_nocin",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1);
        drive("grp1_carry",    32'h0000_00F0, 32'h0000_0010, 1'b0, 32'h0000_0100, 1'b0);
        drive("top_grp",       32'hF000_0000, 32'h1000_0000, 1'b0, 32'h0000_0000, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            ra    = $urandom;
            rb    = $urandom;
            rc    = 1'($urandom_range(0, 1));
            ref33 = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
            drive("random", ra, rb, rc, ref33[31:0], ref33[32]);
        end

        // Asynchronous clear between edges, held across an edge.
        drive("pre_async", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_clear", sum, cout, 32'h0, 1'b0);
        @(posedge clk);
        #1 check("async_hold", sum, cout, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Half-cycle reset pulse while operands change; first post-release edge captures them.
        drive("pre_pulse", 32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0004, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        a   = 32'hDEAD_BEEF;
        b   = 32'h2152_4111;
        cin = 1'b0;
        #1 check("pulse_clear", sum, cout, 32'h0, 1'b0);
        #4 rst_n = 1'b1;
        #1 check("pulse_released", sum, cout, 32'h0, 1'b0);
        begin
            exp_t e;
            e.s = 32'h0000_0000;
            e.c = 1'b1;
            e.name = "post_release";
            sb.push_back(e);
        end

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results pending, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
